// File: rtl/wb_burst_ram.sv
// rtl/wb_burst_ram.sv - Wishbone B4 burst RAM slave; define WB_RAM_ERR_EN for out-of-range ERR responses
module wb_burst_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CYC,
    input  logic                    STB,
    input  logic                    WE,
    input  logic [ADDR_WIDTH-1:0]   ADR,
    input  logic [DATA_WIDTH-1:0]   DAT_O,
    input  logic [DATA_WIDTH/8-1:0] SEL,
    input  logic [2:0]              CTI_O,
    output logic [DATA_WIDTH-1:0]   DAT_I,
    output logic                    ACK,
    output logic                    ERR,
    output logic                    RTY
);
    localparam int LANES      = DATA_WIDTH / 8;
    localparam int LANE_SHIFT = $clog2(LANES);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cur_q, cur_d, cur_inc, rd_idx, adr_idx;
    logic                    ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic                    wr_en, rd_en, dat_clr;
    logic [ADDR_WIDTH-1:0]   adr_word;
    logic                    unused_adr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign adr_word   = ADR >> LANE_SHIFT;
    assign adr_idx    = adr_word[IDX_W-1:0];
    assign cur_inc    = cur_q + IDX_ONE;
    assign unused_adr = ^ADR;

`ifdef WB_RAM_ERR_EN
    logic adr_oor;
    assign adr_oor = (adr_word >> IDX_W) != '0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ack_d   = ack_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = cur_q;
        dat_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (CYC && STB) begin
                    state_d = ACTIVE;
                    cur_d   = adr_idx;
`ifdef WB_RAM_ERR_EN
                    if (adr_oor) begin
                        err_d   = 1'b1;
                        dat_clr = 1'b1;
                    end else
`endif
                    begin
                        ack_d  = 1'b1;
                        rd_en  = 1'b1;
                        rd_idx = adr_idx;
                    end
                end
            end
            ACTIVE: begin
                if (!CYC) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end else if (STB) begin
                    // exactly one of ack_q/err_q is set in ACTIVE, so STB here completes a beat
                    if (err_q) begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        wr_en = WE;
                        if (CTI_O == 3'b010) begin
                            cur_d = cur_inc;
`ifdef WB_RAM_ERR_EN
                            if (&cur_q) begin
                                ack_d   = 1'b0;
                                err_d   = 1'b1;
                                dat_clr = 1'b1;
                            end else
`endif
                            begin
                                rd_en  = 1'b1;
                                rd_idx = cur_inc;
                            end
                        end else begin
                            state_d = IDLE;
                            ack_d   = 1'b0;
                            err_d   = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (dat_clr) begin
                dat_q <= '0;
            end else if (rd_en) begin
                dat_q <= mem[rd_idx];
            end
        end
    end

    // memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (SEL[i]) begin
                    mem[cur_q][i*8 +: 8] <= DAT_O[i*8 +: 8];
                end
            end
        end
    end

    assign DAT_I = dat_q;
    assign ACK   = ack_q & CYC & STB;
`ifdef WB_RAM_ERR_EN
    assign ERR   = err_q & CYC & STB;
`else
    assign ERR   = 1'b0;
`endif
    assign RTY   = 1'b0;
endmodule

// File: tb/tb_wb_burst_ram.sv
// tb/tb_wb_burst_ram.sv - scoreboard testbench for wb_burst_ram
module tb_wb_burst_ram;
    localparam int DW = 32;
    localparam int DEPTH = 4096;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          CYC = 1'b0;
    logic          STB = 1'b0;
    logic          WE = 1'b0;
    logic [AW-1:0] ADR = '0;
    logic [DW-1:0] DAT_O = '0;
    logic [3:0]    SEL = '0;
    logic [2:0]    CTI_O = '0;
    logic [DW-1:0] DAT_I;
    logic          ACK, ERR, RTY;

    wb_burst_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
        .DAT_O(DAT_O), .SEL(SEL), .CTI_O(CTI_O), .DAT_I(DAT_I),
        .ACK(ACK), .ERR(ERR), .RTY(RTY)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] bd [4];
    logic [3:0]  berr;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (ACK || ERR) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: ACK=%b ERR=%b at cycle %0d, expected no beat", ACK, ERR, cyc_cnt);
            end else begin
                mon_e = q.pop_front();
                chk("beat_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
                chk("beat_err", {31'b0, ERR}, {31'b0, mon_e.err});
                chk("beat_ack", {31'b0, ACK}, {31'b0, !mon_e.err});
                if (mon_e.chk) chk("beat_data", DAT_I, mon_e.data);
            end
        end
    end

    task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit err, input logic [31:0] exp_d);
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_O = dat; SEL = sel; CTI_O = 3'b000;
        q.push_back('{cyc: cyc_cnt + 1, err: err, chk: !we, data: exp_d});
        @(posedge clk); @(posedge clk); #1;
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    endtask

    // bd holds write data or expected read data; berr flags beats expected to ERR
    task automatic burst(input bit we, input logic [31:0] adr, input int n, input int wait_at);
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = 4'hF; DAT_O = bd[0];
        CTI_O = (n == 1) ? 3'b111 : 3'b010;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (i == wait_at) begin
                STB = 1'b0;
                @(posedge clk); #1;
                STB = 1'b1;
            end
            ADR = adr + 32'(4 * i);
            DAT_O = bd[i];
            CTI_O = (i == n - 1) ? 3'b111 : 3'b010;
            q.push_back('{cyc: cyc_cnt, err: berr[i], chk: !we, data: berr[i] ? 32'h0 : bd[i]});
            @(posedge clk); #1;
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI_O = 3'b000;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ack", {31'b0, ACK}, 32'h0);
        chk("reset_err", {31'b0, ERR}, 32'h0);
        chk("reset_rty", {31'b0, RTY}, 32'h0);
        chk("reset_dat", DAT_I, 32'h0);
        @(posedge clk); #1;

        classic(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0);
        classic(0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF);

        classic(1, 32'h14, 32'h11223344, 4'hF, 0, 32'h0);
        classic(1, 32'h14, 32'hAABBCCDD, 4'b0101, 0, 32'h0);
        classic(0, 32'h14, 32'h0, 4'hF, 0, 32'h11BB33DD);

        for (int i = 0; i < 4; i++) classic(1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 0, 32'h0);
        bd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        berr = 4'b0000;
        burst(0, 32'h0, 4, -1);

        bd = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        burst(1, 32'h80, 4, 1);
        classic(0, 32'h80, 32'h0, 4'hF, 0, 32'hB0);
        classic(0, 32'h84, 32'h0, 4'hF, 0, 32'hB1);
        classic(0, 32'h88, 32'h0, 4'hF, 0, 32'hB2);
        classic(0, 32'h8C, 32'h0, 4'hF, 0, 32'hB3);

`ifdef WB_RAM_ERR_EN
        classic(0, 32'h4000, 32'h0, 4'hF, 1, 32'h0);
        berr = 4'b0010;
`else
        classic(0, 32'h4000, 32'h0, 4'hF, 0, 32'hA0);
        berr = 4'b0000;
`endif
        classic(1, 32'h3FFC, 32'h5A5A5A5A, 4'hF, 0, 32'h0);
        bd = '{32'h5A5A5A5A, 32'hA0, 32'h0, 32'h0};
        burst(0, 32'h3FFC, 2, -1);

        classic(1, 32'h104, 32'h77777777, 4'hF, 0, 32'h0);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 32'h100; SEL = 4'hF; CTI_O = 3'b010; DAT_O = 32'hC0;
        @(posedge clk); #1;
        q.push_back('{cyc: cyc_cnt, err: 1'b0, chk: 1'b0, data: 32'h0});
        @(posedge clk); #1;
        ADR = 32'h104; DAT_O = 32'hC1; rst = 1'b1;
        q.push_back('{cyc: cyc_cnt, err: 1'b0, chk: 1'b0, data: 32'h0});
        @(posedge clk); #1;
        rst = 1'b0; WE = 1'b0; ADR = 32'h100; CTI_O = 3'b000;
        q.push_back('{cyc: cyc_cnt + 1, err: 1'b0, chk: 1'b1, data: 32'hC0});
        @(negedge clk);
        chk("post_reset_ack", {31'b0, ACK}, 32'h0);
        chk("post_reset_err", {31'b0, ERR}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        CYC = 1'b0; STB = 1'b0;
        classic(0, 32'h104, 32'h0, 4'hF, 0, 32'h77777777);

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
